// File: rtl/irq_vec_ctrl.sv
// irq_vec_ctrl: edge-detected pending sources, masked and arbitrated into
// one held irq with vector address; optional IRQ_VEC_RR_EN = round-robin.
//
// Ports:
//   clk     clock, all state on rising edge
//   rst     synchronous active-high reset
//   done    [N_SRC]  source event lines (rising edge = event)
//   mask    [N_SRC]  1 = source may be granted
//   ack     CPU acknowledge, only honoured while a request is up
//   EAddr   [ADDR_W] vector address of current request
//   irq_id  [IDW]    index of current request
//   irq     interrupt request
//   ovf     one-cycle pulse, event merged into a pending source
module irq_vec_ctrl #(
  parameter int N_SRC = 4,
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] VEC_BASE = '0,
  parameter int VEC_STRIDE = 4,
  localparam int IDW = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_SRC-1:0]  done,
  input  logic [N_SRC-1:0]  mask,
  input  logic              ack,
  output logic [ADDR_W-1:0] EAddr,
  output logic [IDW-1:0]    irq_id,
  output logic              irq,
  output logic              ovf
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ASSERT,
    ST_GAP
  } state_t;

  state_t state, state_n;

  logic [N_SRC-1:0] done_q;
  logic [N_SRC-1:0] pending;
  logic [N_SRC-1:0] pend_n;
  logic [N_SRC-1:0] evt;
  logic [N_SRC-1:0] clr;
  logic [N_SRC-1:0] elig;
  logic             take;
  logic             ovf_n;
  logic             any;
  logic [IDW-1:0]   win;
  logic             irq_n;
  logic [IDW-1:0]   id_n;
  logic [ADDR_W-1:0] addr_n;

  // Set wins over clear: evt is OR'd in after the ack clear.
  always_comb begin
    evt  = done & ~done_q;
    elig = pending & mask;
    take = (state == ST_ASSERT) && ack;
    clr  = '0;
    for (int i = 0; i < N_SRC; i++) begin
      clr[i] = take && (irq_id == IDW'(i));
    end
    pend_n = (pending & ~clr) | evt;
    ovf_n  = |(evt & pending & ~clr);
  end

`ifdef IRQ_VEC_RR_EN
  logic [IDW-1:0] ptr;

  // Descending scan: last hit is the first
  // eligible index at or after ptr.
  always_comb begin
    win = '0;
    any = 1'b0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      if (elig[(int'(ptr) + k) % N_SRC]) begin
        win = IDW'((int'(ptr) + k) % N_SRC);
        any = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (take) begin
      if (irq_id == IDW'(N_SRC - 1)) begin
        ptr <= '0;
      end else begin
        ptr <= irq_id + 1'b1;
      end
    end
  end
`else
  always_comb begin
    win = '0;
    any = 1'b0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (elig[i]) begin
        win = IDW'(i);
        any = 1'b1;
      end
    end
  end
`endif

  always_comb begin
    state_n = state;
    irq_n   = irq;
    id_n    = irq_id;
    addr_n  = EAddr;
    unique case (state)
      ST_IDLE: begin
        if (any) begin
          state_n = ST_ASSERT;
          irq_n   = 1'b1;
          id_n    = win;
          addr_n  = VEC_BASE
                  + ADDR_W'(win) * ADDR_W'(VEC_STRIDE);
        end
      end
      ST_ASSERT: begin
        if (ack) begin
          state_n = ST_GAP;
          irq_n   = 1'b0;
        end
      end
      ST_GAP: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
        irq_n   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      done_q  <= '0;
      pending <= '0;
      ovf     <= 1'b0;
      irq     <= 1'b0;
      irq_id  <= '0;
      EAddr   <= '0;
    end else begin
      state   <= state_n;
      done_q  <= done;
      pending <= pend_n;
      ovf     <= ovf_n;
      irq     <= irq_n;
      irq_id  <= id_n;
      EAddr   <= addr_n;
    end
  end

endmodule
